// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch unit.
package if_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP     = 32'd4;
  localparam logic [XLEN-1:0] BUBBLE_INST = 32'h0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Small synchronous FIFO of fetch entries with push/pop/clear and occupancy count.
module fetch_buf
  import if_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t wdata,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;

  assign do_pop  = pop && (count != '0);
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: in-order request/response to imem, output buffer to ID.
// Define IF_PERF_CNT_EN to add perf_fetched / perf_dropped counters.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] IF_pc,
  output logic [XLEN-1:0] IF_inst,
  output logic            IF_valid,
  output logic            flush
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_dropped
`endif
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   pend_cnt, buf_cnt, drop_cnt;
  logic [CW+1:0]   inflight;
  logic            grant, rsp_take, pop;
  fetch_entry_t    pend_wdata, pend_head, buf_wdata, buf_head;

  assign inflight  = (CW+2)'(drop_cnt) + (CW+2)'(pend_cnt) + (CW+2)'(buf_cnt);
  assign imem_req  = rst && !redirect && (inflight < (CW+2)'(DEPTH));
  assign imem_addr = fetch_pc;
  assign grant     = imem_req && imem_gnt;
  assign flush     = redirect;

  // responses for requests issued before a redirect drain through drop_cnt first
  assign rsp_take  = imem_rvalid && (drop_cnt == '0) && (pend_cnt != '0);
  assign IF_valid  = (buf_cnt != '0);
  assign pop       = IF_valid && !stall && !redirect;
  assign IF_pc     = IF_valid ? buf_head.pc   : '0;
  assign IF_inst   = IF_valid ? buf_head.inst : BUBBLE_INST;

  assign pend_wdata = '{pc: fetch_pc, inst: BUBBLE_INST};

  always_comb begin
    buf_wdata      = pend_head;
    buf_wdata.inst = imem_rdata;
  end

  fetch_buf #(.DEPTH(DEPTH)) u_pend (
    .clk(clk), .rst(rst), .push(grant), .pop(rsp_take), .clear(redirect),
    .wdata(pend_wdata), .head(pend_head), .count(pend_cnt)
  );

  fetch_buf #(.DEPTH(DEPTH)) u_buf (
    .clk(clk), .rst(rst), .push(rsp_take && !redirect), .pop(pop), .clear(redirect),
    .wdata(buf_wdata), .head(buf_head), .count(buf_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      drop_cnt <= drop_cnt + pend_cnt
                - CW'(imem_rvalid && ((drop_cnt != '0) || (pend_cnt != '0)));
    end else begin
      if (grant) fetch_pc <= fetch_pc + PC_STEP;
      if (imem_rvalid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic rsp_discard;
  assign rsp_discard = imem_rvalid && ((drop_cnt != '0) || (redirect && (pend_cnt != '0)));

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(pop);
      perf_dropped <= perf_dropped + 32'(rsp_discard) + (redirect ? 32'(buf_cnt) : 32'd0);
    end
  end
`endif

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter DEPTH, default 2, maximum instructions in flight plus buffered (legal values 2 or 4).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 stall  input  1  ID cannot accept; hold current IF outputs.
REQ-006 redirect  input  1  taken branch/jump from EX; highest priority.
REQ-007 redirect_pc  input  32  new fetch address, valid with redirect.
REQ-008 imem_req  output  1  fetch request to instruction memory.
REQ-009 imem_addr  output  32  request address (current fetch PC).
REQ-010 imem_gnt  input  1  request accepted this cycle when imem_req=1.
REQ-011 imem_rvalid  input  1  in-order response valid, at least 1 cycle after its grant.
REQ-012 imem_rdata  input  32  response instruction word.
REQ-013 IF_pc  output  32  PC of presented instruction; drives IF/ID register.
REQ-014 IF_inst  output  32  presented instruction; 0 when no valid instruction.
REQ-015 IF_valid  output  1  IF_pc/IF_inst hold a real instruction.
REQ-016 flush  output  1  kill IF/ID contents; equals redirect, combinational.

Function
REQ-017 fetch_pc register drives imem_addr; advances by 4 (mod 2^32, wrap 32'hFFFF_FFFC->0) on imem_req&imem_gnt.
REQ-018 imem_req = rst & ~redirect & (drop_cnt + pend_cnt + buf_cnt < DEPTH).
REQ-019 On grant, fetch_pc pushed to pending-PC queue; on imem_rvalid with drop_cnt=0, head pending PC paired with imem_rdata and pushed to output buffer (same cycle pop and push permitted).
REQ-020 imem_rvalid with drop_cnt>0: response discarded, drop_cnt decremented.
REQ-021 IF_valid = buffer non-empty; IF_pc/IF_inst = buffer head; both 0 when empty.
REQ-022 Buffer pops when IF_valid & ~stall & ~redirect; stall holds outputs unchanged.
REQ-023 Redirect: fetch_pc <= redirect_pc; buffer and pending queue cleared; drop_cnt <= drop_cnt + pend_cnt - imem_rvalid; no request issued that cycle; stall ignored.
REQ-024 First request to redirect_pc issued the cycle after redirect; first valid IF output no earlier than 2 cycles after that grant's response... i.e. response registered into buffer, visible next cycle.
REQ-025 Response latency through block: imem_rvalid in cycle N -> IF_valid in cycle N+1.
REQ-026 imem_rvalid with no pending and drop_cnt=0 is a protocol error; ignored (assertion in bench).

Reset
REQ-027 With rst=0 at posedge: fetch_pc=RESET_PC, pend_cnt=buf_cnt=drop_cnt=0; IF_valid=0, IF_pc=0, IF_inst=0; imem_req=0 while rst=0.
REQ-028 Reset mid-operation discards all in-flight responses; memory is reset with the same rst, so no drop tracking across reset.

Configuration
REQ-029 Macro IF_PERF_CNT_EN defined: adds outputs perf_fetched (32, count of instructions popped to ID) and perf_dropped (32, count of discarded responses plus buffer entries cleared by redirect), both reset to 0, wrap at 2^32.
REQ-030 Macro undefined: those ports and counters absent; all other behaviour identical.

Structure
REQ-031 Shared package if_pkg holds XLEN=32, PC_STEP=4, BUBBLE_INST=32'h0, and fetch-entry struct {pc, inst}.
REQ-032 One sub-module fetch_buf: synchronous FIFO of fetch entries, depth DEPTH, push/pop/clear, count output; instantiated for output buffer (pending-PC queue may reuse it with inst unused).

Verification
REQ-033 Reset release, memory gnt=1 latency 1 -> imem_addr 0,4,8,...; IF_pc 0 with IF_valid in cycle 3 after release; one instruction per cycle steady state.
REQ-034 stall held 3 cycles with buffer full (DEPTH=2) -> imem_req=0, IF_pc/IF_inst unchanged, no lost or duplicated PCs after release.
REQ-035 redirect to 32'h100 with 2 responses in flight -> flush=1 that cycle, both late responses discarded, next IF_pc=32'h100, perf_dropped+=2 (IF_PERF_CNT_EN).
REQ-036 redirect coincident with imem_rvalid and stall -> response dropped, stall ignored, drop_cnt = pend_cnt-1, next fetch 32'h100.
REQ-037 redirect_pc=32'hFFFF_FFFC -> fetch addresses FFFF_FFFC then 0000_0000.
REQ-038 rst asserted with pending=2, buffer=1 -> next cycle all outputs 0, first request to RESET_PC one cycle after rst release.
